// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-to-parallel deserializer with valid/ready word output
// Shifts DW serial bits into a word, holds it until accepted, and flags bits dropped while holding.
module sipo_deser #(
  parameter int DW        = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ser_vld,
  input  logic          ser_in,
  input  logic          par_rdy,
  output logic          par_vld,
  output logic [DW-1:0] par_out,
  output logic          busy,
  output logic          ovf
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] sh_q, sh_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] shifted;

  always_comb begin
    if (MSB_FIRST) shifted = {sh_q[DW-2:0], ser_in};
    else           shifted = {ser_in, sh_q[DW-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (ser_vld) begin
          sh_d    = shifted;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_vld) begin
          sh_d = shifted;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // A bit arriving with the handshake starts the next word without a bubble.
        if (par_rdy) begin
          if (ser_vld) begin
            sh_d    = shifted;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (ser_vld) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    par_vld = (state_q == HOLD);
    busy    = (state_q != IDLE);
    par_out = sh_q;
    ovf     = ovf_q;
  end

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - self-checking bench for sipo_deser in both bit orders
module tb_sipo_deser;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, ser_vld, ser_in, par_rdy;
  logic          m_vld, m_busy, m_ovf;
  logic [DW-1:0] m_out;
  logic          l_vld, l_busy, l_ovf;
  logic [DW-1:0] l_out;

  sipo_deser #(.DW(DW), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .ser_vld(ser_vld), .ser_in(ser_in),
    .par_rdy(par_rdy), .par_vld(m_vld), .par_out(m_out), .busy(m_busy), .ovf(m_ovf)
  );

  sipo_deser #(.DW(DW), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .ser_vld(ser_vld), .ser_in(ser_in),
    .par_rdy(par_rdy), .par_vld(l_vld), .par_out(l_out), .busy(l_busy), .ovf(l_ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  bit            b_hold = 1'b0;
  bit            b_ovf  = 1'b0;
  bit            bits_q[$];
  logic [DW-1:0] exp_msb_q[$];
  logic [DW-1:0] exp_lsb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: advance by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [DW-1:0] wm, wl;
    if (rst || clr) begin
      bits_q.delete();
      exp_msb_q.delete();
      exp_lsb_q.delete();
      b_hold = 1'b0;
      b_ovf  = 1'b0;
    end else begin
      if (b_hold && par_rdy) begin
        b_hold = 1'b0;
        void'(exp_msb_q.pop_front());
        void'(exp_lsb_q.pop_front());
      end
      if (ser_vld) begin
        if (b_hold) begin
          b_ovf = 1'b1;
        end else begin
          bits_q.push_back(ser_in);
          if (bits_q.size() == DW) begin
            wm = '0;
            wl = '0;
            for (int i = 0; i < DW; i++) begin
              wm[DW-1-i] = bits_q[i];
              wl[i]      = bits_q[i];
            end
            exp_msb_q.push_back(wm);
            exp_lsb_q.push_back(wl);
            bits_q.delete();
            b_hold = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("msb_vld", m_vld, b_hold);
    chk("lsb_vld", l_vld, b_hold);
    chk("msb_busy", m_busy, b_hold || (bits_q.size() != 0));
    chk("lsb_busy", l_busy, b_hold || (bits_q.size() != 0));
    chk("msb_ovf", m_ovf, b_ovf);
    chk("lsb_ovf", l_ovf, b_ovf);
    if (b_hold) begin
      chk("msb_word_q", m_out, exp_msb_q[0]);
      chk("lsb_word_q", l_out, exp_lsb_q[0]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic d, input logic r);
    ser_vld = v;
    ser_in  = d;
    par_rdy = r;
    tick();
  endtask

  // Bits are sent from w[DW-1] down to w[0].
  task automatic send_word(input logic [DW-1:0] w, input logic r);
    for (int i = DW - 1; i >= 0; i--) drive(1'b1, w[i], r);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; clr = 1'b0; ser_vld = 1'b0; ser_in = 1'b0; par_rdy = 1'b0;
    tick();
    tick();
    chk("reset_msb_out", m_out, 4'h0);
    chk("reset_lsb_out", l_out, 4'h0);
    rst = 1'b0;

    // Bits 1,0,1,1 back to back
    send_word(4'b1011, 1'b1);
    chk("t1_msb_out", m_out, 4'hB);
    chk("t1_lsb_out", l_out, 4'hD);
    chk("t1_vld", m_vld, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("t1_vld_drop", m_vld, 1'b0);

    // Gap of 3 idle cycles mid-word
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      chk("t2_gap_busy", l_busy, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    chk("t2_lsb_out", l_out, 4'hD);
    chk("t2_msb_out", m_out, 4'hB);
    drive(1'b0, 1'b0, 1'b1);

    // Backpressure with dropped bits
    send_word(4'b0110, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("t3_msb_held", m_out, 4'h6);
    chk("t3_vld_held", m_vld, 1'b1);
    chk("t3_ovf", m_ovf, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("t3_vld_release", m_vld, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t3_ovf_sticky", m_ovf, 1'b1);
    clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    chk("t3_ovf_clr", m_ovf, 1'b0);

    // Back-to-back words with zero bubbles
    pulses = 0;
    for (int i = DW - 1; i >= 0; i--) begin
      drive(1'b1, 4'hA >> i, 1'b1);
      pulses += int'(m_vld);
    end
    chk("t4_first_word", m_out, 4'hA);
    for (int i = DW - 1; i >= 0; i--) begin
      drive(1'b1, 4'h5 >> i, 1'b1);
      pulses += int'(m_vld);
    end
    chk("t4_second_word", m_out, 4'h5);
    drive(1'b0, 1'b0, 1'b1);
    pulses += int'(m_vld);
    chk("t4_pulses", pulses, 2);
    chk("t4_ovf", m_ovf, 1'b0);

    // clr discards a partial word
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    clr = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    clr = 1'b0;
    chk("t5_busy_after_clr", m_busy, 1'b0);
    send_word(4'b0111, 1'b1);
    chk("t5_msb_out", m_out, 4'h7);
    chk("t5_lsb_out", l_out, 4'hE);
    drive(1'b0, 1'b0, 1'b1);

    // rst during HOLD, then rst and clr together
    send_word(4'hF, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("t6_rst_out", m_out, 4'h0);
    chk("t6_rst_vld", m_vld, 1'b0);
    chk("t6_rst_busy", m_busy, 1'b0);
    chk("t6_rst_ovf", m_ovf, 1'b0);
    send_word(4'hF, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    rst = 1'b1; clr = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    rst = 1'b0; clr = 1'b0;
    chk("t6_both_out", l_out, 4'h0);
    chk("t6_both_vld", l_vld, 1'b0);
    chk("t6_both_busy", l_busy, 1'b0);
    chk("t6_both_ovf", l_ovf, 1'b0);
    send_word(4'b1001, 1'b1);
    chk("t6_fresh_msb", m_out, 4'h9);
    drive(1'b0, 1'b0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
